fg_key_ctrl: RTL and testbench
==============================

FG_KEY_CTRL -- requirements
Module: fg_key_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning stable-level cycles per key debounce (20 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, meaning held cycles before first auto-repeat (500 ms).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, meaning cycles between auto-repeats (100 ms).
REQ-004 SHALL have parameter FREQ_IDX_MAX, default 15, meaning top frequency index.
REQ-005 SHALL have parameter FREQ_BASE_WORD, default 32'd85899, meaning DDS phase step at index 0 (1 kHz at 50 MHz, 32-bit accumulator).
REQ-006 sys_clk  in  1  system clock; one clock only.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 freq_up_key  in  1  raw push button, active-low, asynchronous.
REQ-009 freq_down_key  in  1  raw push button, active-low, asynchronous.
REQ-010 wave_form_key  in  1  raw push button, active-low, asynchronous.
REQ-011 freq_idx  out  4  current frequency index, 0..FREQ_IDX_MAX.
REQ-012 freq_word  out  32  DDS phase increment = FREQ_BASE_WORD * (freq_idx + 1), truncated to 32 bits.
REQ-013 wave_sel  out  2  waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-014 param_valid  out  1  one-cycle pulse when freq_word or wave_sel changes; downstream LCD redraw trigger.

Function
REQ-015 Each key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-016 Debounce: stable level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any equal sample clears the counter.
REQ-017 Press event SHALL be a one-cycle pulse on the stable 1->0 transition; release generates no event.
REQ-018 Latency: with clean input, freq_idx/wave_sel SHALL update exactly DEBOUNCE_CYCLES+3 rising edges after the first edge sampling the key low; freq_word and param_valid one edge later.
REQ-019 Up event: freq_idx+1, saturating at FREQ_IDX_MAX; down event: freq_idx-1, saturating at 0.
REQ-020 Event at saturation SHALL leave freq_idx, freq_word unchanged and SHALL NOT pulse param_valid.
REQ-021 Up and down events in the same cycle SHALL both be ignored.
REQ-022 Wave event: wave_sel 0->1->2->3->0 wrap; no auto-repeat for wave key.
REQ-023 Wave event coincident with a freq event SHALL apply both; single param_valid pulse.
REQ-024 Per freq key, auto-repeat FSM: IDLE -(press)-> DELAY; DELAY -(REPEAT_DELAY cycles held)-> REPEAT with one event; REPEAT emits one event every REPEAT_PERIOD cycles; any state -(stable release)-> IDLE.
REQ-025 Both freq keys held: repeat events coincide or are per-key independent; REQ-021 applies to any coinciding pair.
REQ-026 freq_word SHALL be registered; multiplication by constant, no combinational path from keys to outputs.

Reset
REQ-027 rst_n low SHALL immediately force: freq_idx 0, wave_sel 0, freq_word FREQ_BASE_WORD, param_valid 0, synchronizers and stable levels 1 (released), all counters 0, FSMs IDLE.
REQ-028 A key held low across reset release SHALL be debounced as a fresh press (REQ-018 timing from first edge after release).
REQ-029 Reset mid-debounce or mid-repeat SHALL discard the pending event; no param_valid pulse after release.

Structure
REQ-030 Shared package fg_pkg SHALL hold wave_sel encodings (WAVE_SINE..WAVE_SAW), FREQ_IDX_W = 4, and default timing constants.
REQ-031 Sub-module key_debounce (synchronizer, debounce counter, stable level, press pulse) SHALL be instantiated three times; repeat FSM and parameter registers live in fg_key_ctrl.

Verification (bench params: DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10, 20 ns clock)
REQ-032 Clean up press held 20 cycles from reset -> freq_idx 0->1 at edge 11, freq_word 2*FREQ_BASE_WORD and one param_valid pulse at edge 12.
REQ-033 Up key bouncing low/high every 3 cycles for 30 cycles, then low -> exactly one increment, 11 edges after final stable low.
REQ-034 Up held 100 cycles from idx 0 -> idx 1 at press, 2 at +40, then +1 every 10 cycles (idx 7 at end); at idx 15 further repeats -> no change, no param_valid.
REQ-035 Down press at idx 0 -> idx stays 0, no pulse; up and down pressed same edge -> no change.
REQ-036 Five wave presses -> wave_sel 1,2,3,0,1, one param_valid each; wave held 100 cycles -> single step.
REQ-037 rst_n asserted 4 cycles into debounce -> outputs at reset values immediately; key still low after release -> press at edge 11 post-release.

Source files
------------

// File: rtl/fg_key_ctrl_pkg.sv
// Shared encodings and default timing for the key controller.
// Exports wave encodings, index width, default timings, width helper.
package fg_pkg;

  localparam int FREQ_IDX_W = 4;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;
  localparam int unsigned DEF_FREQ_IDX_MAX    = 15;
  localparam logic [31:0] DEF_FREQ_BASE_WORD  = 32'd85899;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_e;

  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fg_key_ctrl_if.sv
// Key inputs and parameter outputs of the key controller.
// slave: controller side; master: board/driver side.
interface fg_key_ctrl_if;
  import fg_pkg::*;

  logic                  freq_up_key;
  logic                  freq_down_key;
  logic                  wave_form_key;
  logic [FREQ_IDX_W-1:0] freq_idx;
  logic [31:0]           freq_word;
  logic [1:0]            wave_sel;
  logic                  param_valid;

  modport master (
    output freq_up_key,
    output freq_down_key,
    output wave_form_key,
    input  freq_idx,
    input  freq_word,
    input  wave_sel,
    input  param_valid
  );

  modport slave (
    input  freq_up_key,
    input  freq_down_key,
    input  wave_form_key,
    output freq_idx,
    output freq_word,
    output wave_sel,
    output param_valid
  );

endinterface

// File: rtl/fg_key_ctrl_debounce.sv
// One push button: 2-flop sync, debounce counter, stable level, press pulse.
// Ports: clk, rst_n, key_n (raw, active-low) -> level, press.
module key_debounce
  import fg_pkg::*;
#(
  parameter int unsigned CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int unsigned CW = cnt_w(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Nth consecutive differing sample: accept new level.
        level <= s2;
        cnt   <= '0;
        press <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fg_key_ctrl.sv
// Function-generator key controller: frequency index/word and waveform.
// Ports: sys_clk, rst_n, bus (keys in; idx, word, wave, param_valid out).
module fg_key_ctrl
  import fg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned FREQ_IDX_MAX    = DEF_FREQ_IDX_MAX,
  parameter logic [31:0] FREQ_BASE_WORD  = DEF_FREQ_BASE_WORD
) (
  input logic         sys_clk,
  input logic         rst_n,
  fg_key_ctrl_if.slave bus
);

  localparam int unsigned RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCW = cnt_w(RMAX);
  localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RP_LAST = RCW'(REPEAT_PERIOD - 1);
  localparam logic [FREQ_IDX_W-1:0] IDX_MAX =
    FREQ_IDX_W'(FREQ_IDX_MAX);

  logic [2:0] lvl;
  logic [2:0] prs;

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .key_n (bus.freq_up_key),
    .level (lvl[0]),
    .press (prs[0])
  );

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .key_n (bus.freq_down_key),
    .level (lvl[1]),
    .press (prs[1])
  );

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_wv (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .key_n (bus.wave_form_key),
    .level (lvl[2]),
    .press (prs[2])
  );

  rpt_e           st_q [2];
  rpt_e           st_d [2];
  logic [RCW-1:0] rc_q [2];
  logic [RCW-1:0] rc_d [2];
  logic [1:0]     rep_ev;
  logic [1:0]     f_ev;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        st_q[k] <= RPT_IDLE;
        rc_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        st_q[k] <= st_d[k];
        rc_q[k] <= rc_d[k];
      end
    end
  end

  // Released stable level (lvl high) always returns to idle.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      st_d[k]   = st_q[k];
      rc_d[k]   = rc_q[k];
      rep_ev[k] = 1'b0;
      unique case (st_q[k])
        RPT_IDLE: begin
          if (prs[k]) begin
            st_d[k] = RPT_DELAY;
            rc_d[k] = '0;
          end
        end
        RPT_DELAY: begin
          if (lvl[k]) begin
            st_d[k] = RPT_IDLE;
            rc_d[k] = '0;
          end else if (rc_q[k] == RD_LAST) begin
            st_d[k]   = RPT_REPEAT;
            rc_d[k]   = '0;
            rep_ev[k] = 1'b1;
          end else begin
            rc_d[k] = rc_q[k] + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (lvl[k]) begin
            st_d[k] = RPT_IDLE;
            rc_d[k] = '0;
          end else if (rc_q[k] == RP_LAST) begin
            rc_d[k]   = '0;
            rep_ev[k] = 1'b1;
          end else begin
            rc_d[k] = rc_q[k] + 1'b1;
          end
        end
        default: begin
          st_d[k] = RPT_IDLE;
          rc_d[k] = '0;
        end
      endcase
    end
  end

  assign f_ev = prs[1:0] | rep_ev;

  logic                  up_ev;
  logic                  dn_ev;
  logic [FREQ_IDX_W-1:0] idx_q;
  logic [FREQ_IDX_W-1:0] idx_d;
  logic [1:0]            wave_q;
  logic [1:0]            wave_d;
  logic                  chg_q;
  logic                  chg_d;
  logic [31:0]           word_q;
  logic                  pv_q;

  // Coincident up/down cancel each other.
  assign up_ev = f_ev[0] & ~f_ev[1];
  assign dn_ev = f_ev[1] & ~f_ev[0];

  always_comb begin
    idx_d = idx_q;
    unique case (1'b1)
      up_ev && (idx_q != IDX_MAX): idx_d = idx_q + 1'b1;
      dn_ev && (idx_q != '0):      idx_d = idx_q - 1'b1;
      default:                     idx_d = idx_q;
    endcase
  end

  assign wave_d = wave_q + {1'b0, prs[2]};
  assign chg_d  = (idx_d != idx_q) || (wave_d != wave_q);

  // Word and pulse trail the index by one edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      wave_q <= WAVE_SINE;
      chg_q  <= 1'b0;
      word_q <= FREQ_BASE_WORD;
      pv_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      wave_q <= wave_d;
      chg_q  <= chg_d;
      word_q <= FREQ_BASE_WORD * (32'(idx_q) + 32'd1);
      pv_q   <= chg_q;
    end
  end

  assign bus.freq_idx    = idx_q;
  assign bus.wave_sel    = wave_q;
  assign bus.freq_word   = word_q;
  assign bus.param_valid = pv_q;

endmodule

// File: tb/tb_fg_key_ctrl.sv
// Bench for fg_key_ctrl: vector table, corner sequences, random vs model.
// Reduced timing: debounce 8, repeat delay 40, period 10.
module tb_fg_key_ctrl;

  localparam int D  = 8;
  localparam int RD = 40;
  localparam int RP = 10;
  localparam int MX = 15;
  localparam logic [31:0] BASE = 32'd85899;

  logic clk;
  logic rst_n;
  fg_key_ctrl_if bus();

  fg_key_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .FREQ_IDX_MAX    (MX),
    .FREQ_BASE_WORD  (BASE)
  ) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pv_cnt = 0;
  bit chk_en = 0;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d t=%0t",
        name, act, exp, $time);
    end
  endtask

  task automatic set_keys(input bit up, input bit dn, input bit wv);
    bus.freq_up_key   = !up;
    bus.freq_down_key = !dn;
    bus.wave_form_key = !wv;
  endtask

  // Reference model: debounce as "last D synced samples all differ",
  // repeats as a function of cycles since the stable press.
  int          m_idx;
  int          m_wave;
  logic [31:0] m_word;
  bit          m_pv;
  bit          m_chg;
  bit          m_s1 [3];
  bit          m_s2 [3];
  bit          m_lvl [3];
  logic [D-1:0] m_hist [3];
  int          m_held [3];

  task automatic m_reset();
    m_idx = 0;
    m_wave = 0;
    m_word = BASE;
    m_pv = 0;
    m_chg = 0;
    for (int k = 0; k < 3; k++) begin
      m_s1[k] = 1;
      m_s2[k] = 1;
      m_lvl[k] = 1;
      m_hist[k] = '1;
      m_held[k] = 0;
    end
  endtask

  task automatic m_step();
    bit ev [3];
    bit up;
    bit dn;
    int ni;
    int nw;
    bit [2:0] keys;
    keys = {bus.wave_form_key, bus.freq_down_key, bus.freq_up_key};
    for (int k = 0; k < 3; k++) begin
      int h;
      h = m_held[k];
      ev[k] = !m_lvl[k] && (h == 0 || (k < 2 &&
        (h == RD || (h > RD && (h - RD) % RP == 0))));
    end
    up = ev[0] && !ev[1];
    dn = ev[1] && !ev[0];
    ni = m_idx;
    if (up && ni < MX) ni++;
    else if (dn && ni > 0) ni--;
    nw = ev[2] ? (m_wave + 1) % 4 : m_wave;
    m_pv = m_chg;
    m_word = BASE * 32'(m_idx + 1);
    m_chg = (ni != m_idx) || (nw != m_wave);
    m_idx = ni;
    m_wave = nw;
    for (int k = 0; k < 3; k++) begin
      if (!m_lvl[k]) m_held[k]++;
      m_hist[k] = {m_hist[k][D-2:0], m_s2[k]};
      if (m_hist[k] == {D{!m_lvl[k]}}) begin
        m_lvl[k] = !m_lvl[k];
        m_held[k] = 0;
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = keys[k];
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.param_valid) pv_cnt++;
      if (chk_en) begin
        check("mdl_idx", bus.freq_idx, m_idx);
        check("mdl_wave", bus.wave_sel, m_wave);
        check("mdl_word", bus.freq_word, m_word);
        check("mdl_pv", bus.param_valid, m_pv);
      end
    end
  end

  typedef struct {
    bit up;
    bit dn;
    bit wv;
    int hold;
    int e_idx;
    int e_wave;
    int e_pv;
  } vec_t;

  vec_t tbl [$];

  task automatic do_reset();
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    tbl.push_back('{1, 0, 0, 20, 1, 0, 1});
    tbl.push_back('{1, 0, 0, 20, 2, 0, 1});
    tbl.push_back('{0, 1, 0, 20, 1, 0, 1});
    tbl.push_back('{0, 1, 0, 20, 0, 0, 1});
    tbl.push_back('{0, 1, 0, 20, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 20, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 100, 7, 0, 7});
    tbl.push_back('{1, 0, 0, 100, 14, 0, 7});
    tbl.push_back('{1, 0, 0, 100, 15, 0, 1});
    tbl.push_back('{1, 0, 0, 20, 15, 0, 0});
    tbl.push_back('{0, 0, 1, 100, 15, 1, 1});
    tbl.push_back('{0, 0, 1, 20, 15, 2, 1});
    tbl.push_back('{0, 0, 1, 20, 15, 3, 1});
    tbl.push_back('{0, 0, 1, 20, 15, 0, 1});
    tbl.push_back('{0, 1, 1, 20, 14, 1, 1});
    tbl.push_back('{0, 1, 0, 45, 12, 1, 2});
    tbl.push_back('{1, 1, 0, 60, 12, 1, 0});
    tbl.push_back('{1, 0, 1, 20, 13, 2, 1});

    rst_n = 0;
    set_keys(0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_idx", bus.freq_idx, 0);
    check("rst_wave", bus.wave_sel, 0);
    check("rst_word", bus.freq_word, BASE);
    check("rst_pv", bus.param_valid, 0);
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);

    // Clean press latency.
    set_keys(1, 0, 0);
    repeat (10) @(negedge clk);
    check("lat_e10_idx", bus.freq_idx, 0);
    @(negedge clk);
    check("lat_e11_idx", bus.freq_idx, 1);
    check("lat_e11_pv", bus.param_valid, 0);
    check("lat_e11_word", bus.freq_word, BASE);
    @(negedge clk);
    check("lat_e12_word", bus.freq_word, 2 * BASE);
    check("lat_e12_pv", bus.param_valid, 1);
    @(negedge clk);
    check("lat_e13_pv", bus.param_valid, 0);
    repeat (7) @(negedge clk);
    set_keys(0, 0, 0);
    repeat (25) @(negedge clk);
    do_reset();

    // Bouncing key, then a clean low.
    pv_cnt = 0;
    for (int b = 0; b < 5; b++) begin
      set_keys(1, 0, 0);
      repeat (3) @(negedge clk);
      set_keys(0, 0, 0);
      repeat (3) @(negedge clk);
    end
    check("bnc_idx_pre", bus.freq_idx, 0);
    set_keys(1, 0, 0);
    repeat (10) @(negedge clk);
    check("bnc_e10_idx", bus.freq_idx, 0);
    @(negedge clk);
    check("bnc_e11_idx", bus.freq_idx, 1);
    repeat (9) @(negedge clk);
    set_keys(0, 0, 0);
    repeat (25) @(negedge clk);
    check("bnc_idx", bus.freq_idx, 1);
    check("bnc_pv", pv_cnt, 1);
    do_reset();

    foreach (tbl[i]) begin
      pv_cnt = 0;
      set_keys(tbl[i].up, tbl[i].dn, tbl[i].wv);
      repeat (tbl[i].hold) @(negedge clk);
      set_keys(0, 0, 0);
      repeat (25) @(negedge clk);
      check($sformatf("vec%0d_idx", i), bus.freq_idx, tbl[i].e_idx);
      check($sformatf("vec%0d_wave", i), bus.wave_sel, tbl[i].e_wave);
      check($sformatf("vec%0d_word", i), bus.freq_word,
        BASE * 32'(tbl[i].e_idx + 1));
      check($sformatf("vec%0d_pv", i), pv_cnt, tbl[i].e_pv);
    end

    // Reset in the middle of a debounce, key kept low.
    set_keys(1, 0, 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("mid_rst_idx", bus.freq_idx, 0);
    check("mid_rst_wave", bus.wave_sel, 0);
    check("mid_rst_word", bus.freq_word, BASE);
    check("mid_rst_pv", bus.param_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    pv_cnt = 0;
    repeat (10) @(negedge clk);
    check("post_e10_idx", bus.freq_idx, 0);
    @(negedge clk);
    check("post_e11_idx", bus.freq_idx, 1);
    check("post_e11_pv", bus.param_valid, 0);
    @(negedge clk);
    check("post_e12_word", bus.freq_word, 2 * BASE);
    check("post_e12_pv", bus.param_valid, 1);
    set_keys(0, 0, 0);
    repeat (25) @(negedge clk);
    check("post_pv_cnt", pv_cnt, 1);

    // Random key activity against the model.
    for (int s = 0; s < 80; s++) begin
      int mode;
      int len;
      bit [2:0] kb;
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        @(negedge clk);
        #3 rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
      end else begin
        kb = 3'($urandom_range(0, 7));
        len = $urandom_range(1, 110);
        set_keys(kb[0], kb[1], kb[2]);
        for (int c = 0; c < len; c++) begin
          @(negedge clk);
          if (mode < 3 && $urandom_range(0, 5) == 0) begin
            kb[$urandom_range(0, 2)] ^= 1'b1;
            set_keys(kb[0], kb[1], kb[2]);
          end
        end
        set_keys(0, 0, 0);
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
    end
    repeat (30) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
